// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer.
package countdown_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/down_count_core.sv
// Loadable down-counting register; it saturates at zero and never wraps.
module down_count_core
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             is_one
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      // Zero guard makes an underflow to all-ones unreachable.
      count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q      = count_q;
  assign is_one = (count_q == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: IDLE/RUN/DONE control FSM with optional auto-reload and a
// registered terminal-count pulse.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  logic             core_clear;
  logic             core_load;
  logic [WIDTH-1:0] core_load_val;
  logic             core_dec;
  logic             core_is_one;

  always_comb begin
    state_d       = state_q;
    reload_d      = reload_q;
    tc_d          = 1'b0;
    core_clear    = 1'b0;
    core_load     = 1'b0;
    core_load_val = load_val;
    core_dec      = 1'b0;

    if (abort) begin
      state_d    = IDLE;
      core_clear = 1'b1;
    end else if (start) begin
      if (load_val != '0) begin
        state_d   = RUN;
        reload_d  = load_val;
        core_load = 1'b1;
      end else begin
        // A zero-length count terminates immediately.
        state_d    = DONE;
        core_clear = 1'b1;
        tc_d       = 1'b1;
      end
    end else if ((state_q == RUN) && enable) begin
      if (core_is_one) begin
        tc_d = 1'b1;
        if (auto_reload) begin
          core_load     = 1'b1;
          core_load_val = reload_q;
        end else begin
          state_d    = DONE;
          core_clear = 1'b1;
        end
      end else begin
        core_dec = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  down_count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .clear   (core_clear),
    .load    (core_load),
    .load_val(core_load_val),
    .dec     (core_dec),
    .q       (q),
    .is_one  (core_is_one)
  );

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign tc   = tc_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed steps push expected outputs,
// a monitor pops and compares them one clock edge later.
module tb_countdown_timer;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             enable;
  logic             auto_reload;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             tc;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             tc;
    int               id;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  countdown_timer #(
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_val   (load_val),
    .enable     (enable),
    .auto_reload(auto_reload),
    .abort      (abort),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .tc         (tc)
  );

  task automatic check(input string name, input int id, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s step=%0d actual=%0d required=%0d", name, id, act, req);
    end
  endtask

  // Entered and left at posedge+2; the expectation applies after the next edge.
  task automatic step(input logic st, input int lv, input logic en, input logic ar,
                      input logic ab, input int eq, input logic eb, input logic ed,
                      input logic et);
    exp_t e;
    start       = st;
    load_val    = WIDTH'(lv);
    enable      = en;
    auto_reload = ar;
    abort       = ab;
    e.q    = WIDTH'(eq);
    e.busy = eb;
    e.done = ed;
    e.tc   = et;
    e.id   = step_id;
    step_id++;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q", e.id, int'(q), int'(e.q));
        check("busy", e.id, int'(busy), int'(e.busy));
        check("done", e.id, int'(done), int'(e.done));
        check("tc", e.id, int'(tc), int'(e.tc));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1;
    start = 1'b0;
    load_val = '0;
    enable = 1'b0;
    auto_reload = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #2;
    check("reset_q", -1, int'(q), 0);
    check("reset_busy", -1, int'(busy), 0);
    check("reset_done", -1, int'(done), 0);
    check("reset_tc", -1, int'(tc), 0);
    reset = 1'b0;

    // Start on the first edge after release, one-shot count of 3.
    step(1, 3, 1, 0, 0, 3, 1, 0, 0);
    step(0, 0, 1, 0, 0, 2, 1, 0, 0);
    step(0, 0, 1, 0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Auto-reload with N=2.
    step(1, 2, 1, 1, 0, 2, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1, 0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0, 2, 1, 0, 1);
    end

    // Enable gating.
    step(1, 5, 1, 0, 0, 5, 1, 0, 0);
    step(0, 0, 1, 0, 0, 4, 1, 0, 0);
    step(0, 0, 0, 0, 0, 4, 1, 0, 0);
    step(0, 0, 0, 0, 0, 4, 1, 0, 0);
    step(0, 0, 1, 0, 0, 3, 1, 0, 0);

    // Abort beats start; then a zero-length start.
    step(1, 4, 0, 0, 0, 4, 1, 0, 0);
    step(1, 7, 1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0, 0, 0, 1, 0);

    // Auto-reload with N=1 pulses tc every cycle.
    step(1, 1, 1, 1, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 1, 1, 0, 1);
    step(0, 0, 1, 1, 0, 1, 1, 0, 1);

    // Asynchronous reset mid-count at q=6.
    step(1, 6, 0, 0, 0, 6, 1, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    check("async_q", step_id, int'(q), 0);
    check("async_busy", step_id, int'(busy), 0);
    check("async_tc", step_id, int'(tc), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step(0, 0, 1, 1, 0, 0, 0, 0, 0);

    // Full-scale count: no wrap past zero.
    step(1, 15, 1, 0, 0, 15, 1, 0, 0);
    for (int i = 14; i >= 1; i--) begin
      step(0, 0, 1, 0, 0, i, 1, 0, 0);
    end
    step(0, 0, 1, 0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0, 0, 0, 1, 0);

    // Restart while running at q=2.
    step(1, 4, 1, 0, 0, 4, 1, 0, 0);
    step(0, 0, 1, 0, 0, 3, 1, 0, 0);
    step(0, 0, 1, 0, 0, 2, 1, 0, 0);
    step(1, 9, 1, 0, 0, 9, 1, 0, 0);
    step(0, 0, 1, 0, 0, 8, 1, 0, 0);

    @(posedge clk);
    #3;
    check("sb_drained", step_id, sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
